// File: rtl/display_scan_timer.sv
// display_scan_timer: MM:SS stopwatch driving a 4-digit multiplexed 7-segment display.
// clockDisplay and clock1s are slow square waves from the clock divider. They are treated
// as asynchronous data: synchronised, edge-detected and never used as clocks.
// SYNC_STAGES must be 2 or more.
module display_scan_timer #(
  parameter int SYNC_STAGES      = 2,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic       clockPlaca,
  input  logic       reset,
  input  logic       clockDisplay,
  input  logic       clock1s,
  input  logic       run,
  input  logic       clear,
  output logic [6:0] segmentos,
  output logic       ponto,
  output logic [3:0] digito,
  output logic       overflow
);

  // Scan position doubles as the digit selector: su, st, mu, mt from right to left
  typedef enum logic [1:0] {
    SCAN_SU = 2'd0,
    SCAN_ST = 2'd1,
    SCAN_MU = 2'd2,
    SCAN_MT = 2'd3
  } scan_t;

  // Pin levels that leave every digit disabled and every segment dark
  localparam logic [3:0] DIGIT_OFF = {4{DIGIT_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic       DOT_OFF   = SEG_ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] disp_sync;
  logic [SYNC_STAGES-1:0] sec_sync;
  logic                   disp_prev;
  logic                   sec_prev;
  logic                   tick_disp;
  logic                   tick_sec;

  logic [3:0] su;
  logic [3:0] st;
  logic [3:0] mu;
  logic [3:0] mt;
  logic       blink;
  scan_t      scan_idx;

  logic [3:0] sel_digit;
  logic [6:0] seg_on;
  logic [3:0] dig_on;
  logic       dot_on;

  // Active-high {g,f,e,d,c,b,a} pattern for one BCD digit; anything above 9 stays dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Synchronise both divider outputs and keep one extra flop of history for edge detection
  always_ff @(posedge clockPlaca) begin
    if (reset) begin
      disp_sync <= '0;
      sec_sync  <= '0;
      disp_prev <= 1'b0;
      sec_prev  <= 1'b0;
    end else begin
      disp_sync <= {disp_sync[SYNC_STAGES-2:0], clockDisplay};
      sec_sync  <= {sec_sync[SYNC_STAGES-2:0], clock1s};
      disp_prev <= disp_sync[SYNC_STAGES-1];
      sec_prev  <= sec_sync[SYNC_STAGES-1];
    end
  end

  assign tick_disp = disp_sync[SYNC_STAGES-1] & ~disp_prev;
  assign tick_sec  = sec_sync[SYNC_STAGES-1] & ~sec_prev;

  // BCD time counters with ripple carry; clear beats a coincident tick, overflow flags the wrap
  always_ff @(posedge clockPlaca) begin
    if (reset) begin
      su       <= 4'd0;
      st       <= 4'd0;
      mu       <= 4'd0;
      mt       <= 4'd0;
      blink    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (clear) begin
        su    <= 4'd0;
        st    <= 4'd0;
        mu    <= 4'd0;
        mt    <= 4'd0;
        blink <= 1'b0;
      end else if (tick_sec && run) begin
        blink <= ~blink;
        if (su == 4'd9) begin
          su <= 4'd0;
          if (st == 4'd5) begin
            st <= 4'd0;
            if (mu == 4'd9) begin
              mu <= 4'd0;
              if (mt == 4'd5) begin
                mt       <= 4'd0;
                overflow <= 1'b1;
              end else begin
                mt <= mt + 4'd1;
              end
            end else begin
              mu <= mu + 4'd1;
            end
          end else begin
            st <= st + 4'd1;
          end
        end else begin
          su <= su + 4'd1;
        end
      end
    end
  end

  // Scan pointer steps through the four digits on every display tick, regardless of run/clear
  always_ff @(posedge clockPlaca) begin
    if (reset) begin
      scan_idx <= SCAN_SU;
    end else if (tick_disp) begin
      scan_idx <= scan_t'(scan_idx + 2'd1);
    end
  end

  // Pick the digit under the scan pointer and build its active-high segment/enable/dot values
  always_comb begin
    sel_digit = su;
    dig_on    = 4'b0001;
    case (scan_idx)
      SCAN_SU: begin sel_digit = su; dig_on = 4'b0001; end
      SCAN_ST: begin sel_digit = st; dig_on = 4'b0010; end
      SCAN_MU: begin sel_digit = mu; dig_on = 4'b0100; end
      SCAN_MT: begin sel_digit = mt; dig_on = 4'b1000; end
      default: begin sel_digit = su; dig_on = 4'b0001; end
    endcase
    seg_on = seg_decode(sel_digit);
    dot_on = (scan_idx == SCAN_MU) && blink;
  end

  // Register the pins so they change one clock after the pointer or counters, glitch-free
  always_ff @(posedge clockPlaca) begin
    if (reset) begin
      digito    <= DIGIT_OFF;
      segmentos <= SEG_OFF;
      ponto     <= DOT_OFF;
    end else begin
      digito    <= dig_on ^ DIGIT_OFF;
      segmentos <= seg_on ^ SEG_OFF;
      ponto     <= dot_on ^ DOT_OFF;
    end
  end

endmodule

// File: tb/tb_display_scan_timer.sv
// Self-checking bench for display_scan_timer with default parameters (active-low pins).
module tb_display_scan_timer;

  localparam int SYNC = 2;

  logic       clockPlaca = 1'b0;
  logic       reset;
  logic       clockDisplay;
  logic       clock1s;
  logic       run;
  logic       clear;
  logic [6:0] segmentos;
  logic       ponto;
  logic [3:0] digito;
  logic       overflow;

  int checks    = 0;
  int failures  = 0;
  int ovf_count = 0;

  typedef struct {
    bit run;
    bit clr;
    int nsec;
    int mt;
    int mu;
    int st;
    int su;
    bit blink;
  } vec_t;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       pt;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  int         m_digit[4];
  bit         m_blink;
  int         m_idx;
  logic [3:0] last_dig;

  display_scan_timer #(
    .SYNC_STAGES(SYNC),
    .SEG_ACTIVE_LOW(1'b1),
    .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .clockPlaca(clockPlaca),
    .reset(reset),
    .clockDisplay(clockDisplay),
    .clock1s(clock1s),
    .run(run),
    .clear(clear),
    .segmentos(segmentos),
    .ponto(ponto),
    .digito(digito),
    .overflow(overflow)
  );

  // 100 MHz board clock
  always #5 clockPlaca = ~clockPlaca;

  // Count every cycle in which overflow is seen high
  always @(posedge clockPlaca) begin
    #1;
    if (overflow === 1'b1) ovf_count++;
  end

  // Hard stop so a stuck run still ends
  initial begin
    #700000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic set_model(input int mt, input int mu, input int st, input int su, input bit b);
    m_digit[0] = su;
    m_digit[1] = st;
    m_digit[2] = mu;
    m_digit[3] = mt;
    m_blink    = b;
  endtask

  // One clockDisplay period; checks the pins stay put until the exact landing cycle
  task automatic pulse_disp(input string name);
    exp_t       e;
    exp_t       got;
    int         nidx;
    logic [3:0] onehot;
    nidx   = (m_idx + 1) % 4;
    onehot = 4'b0001 << nidx;
    e.dig  = ~onehot;
    e.seg  = ~seg_tbl[m_digit[nidx]];
    e.pt   = ~((nidx == 2) && m_blink);
    sb.push_back(e);
    @(negedge clockPlaca);
    clockDisplay = 1'b1;
    repeat (SYNC + 1) @(posedge clockPlaca);
    #1 checkOutput({name, "_hold"}, 32'(digito), 32'(last_dig));
    @(posedge clockPlaca);
    #1;
    got = sb.pop_front();
    checkOutput({name, "_dig"}, 32'(digito), 32'(got.dig));
    checkOutput({name, "_seg"}, 32'(segmentos), 32'(got.seg));
    checkOutput({name, "_pt"}, 32'(ponto), 32'(got.pt));
    m_idx    = nidx;
    last_dig = got.dig;
    @(negedge clockPlaca);
    clockDisplay = 1'b0;
    repeat (SYNC + 2) @(posedge clockPlaca);
  endtask

  task automatic scan_all(input string name);
    for (int k = 0; k < 4; k++) pulse_disp($sformatf("%s_s%0d", name, k));
  endtask

  // One clock1s period, high for hi cycles
  task automatic pulse_sec(input int hi);
    @(negedge clockPlaca);
    clock1s = 1'b1;
    repeat (hi) @(posedge clockPlaca);
    @(negedge clockPlaca);
    clock1s = 1'b0;
    repeat (3) @(posedge clockPlaca);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clockPlaca);
    run = v.run;
    if (v.clr) begin
      clear = 1'b1;
      @(posedge clockPlaca);
      @(negedge clockPlaca);
      clear = 1'b0;
    end
    for (int k = 0; k < v.nsec; k++) pulse_sec(2);
  endtask

  // Reset for three cycles, checking dark pins while held and digit0 '0' right after release
  task automatic do_reset(input string name);
    @(negedge clockPlaca);
    reset = 1'b1;
    repeat (3) @(posedge clockPlaca);
    #1;
    checkOutput({name, "_held_dig"}, 32'(digito), 32'(4'b1111));
    checkOutput({name, "_held_seg"}, 32'(segmentos), 32'(7'b1111111));
    checkOutput({name, "_held_pt"}, 32'(ponto), 32'(1'b1));
    @(negedge clockPlaca);
    reset = 1'b0;
    @(posedge clockPlaca);
    #1;
    checkOutput({name, "_rel_dig"}, 32'(digito), 32'(4'b1110));
    checkOutput({name, "_rel_seg"}, 32'(segmentos), 32'(7'b1000000));
    checkOutput({name, "_rel_pt"}, 32'(ponto), 32'(1'b1));
    checkOutput({name, "_rel_ovf"}, 32'(overflow), 32'(1'b0));
    set_model(0, 0, 0, 0, 1'b0);
    m_idx    = 0;
    last_dig = 4'b1110;
  endtask

  initial begin
    vecs[0] = '{run: 1'b1, clr: 1'b0, nsec: 10, mt: 0, mu: 0, st: 1, su: 0, blink: 1'b0};
    vecs[1] = '{run: 1'b1, clr: 1'b0, nsec: 55, mt: 0, mu: 1, st: 0, su: 5, blink: 1'b1};
    vecs[2] = '{run: 1'b0, clr: 1'b0, nsec: 5,  mt: 0, mu: 1, st: 0, su: 5, blink: 1'b1};
    vecs[3] = '{run: 1'b1, clr: 1'b1, nsec: 0,  mt: 0, mu: 0, st: 0, su: 0, blink: 1'b0};
    vecs[4] = '{run: 1'b1, clr: 1'b0, nsec: 7,  mt: 0, mu: 0, st: 0, su: 7, blink: 1'b1};

    reset        = 1'b1;
    clockDisplay = 1'b0;
    clock1s      = 1'b0;
    run          = 1'b0;
    clear        = 1'b0;
    do_reset("rst0");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      set_model(vecs[i].mt, vecs[i].mu, vecs[i].st, vecs[i].su, vecs[i].blink);
      scan_all($sformatf("v%0d", i));
    end

    // clear lands on the same cycle as the counted tick at 00:07
    @(negedge clockPlaca);
    clock1s = 1'b1;
    repeat (SYNC) @(posedge clockPlaca);
    @(negedge clockPlaca);
    clear = 1'b1;
    @(posedge clockPlaca);
    #1 checkOutput("clr_tick_ovf", 32'(overflow), 32'(1'b0));
    @(negedge clockPlaca);
    clear   = 1'b0;
    clock1s = 1'b0;
    repeat (3) @(posedge clockPlaca);
    set_model(0, 0, 0, 0, 1'b0);
    scan_all("clr_tick");
    checkOutput("ovf_none_yet", 32'(ovf_count), 32'(0));

    // full hour: the 3600th tick wraps with a one-cycle overflow at tick latency
    for (int k = 0; k < 3599; k++) pulse_sec(2);
    @(negedge clockPlaca);
    clock1s = 1'b1;
    repeat (SYNC) @(posedge clockPlaca);
    #1 checkOutput("ovf_early", 32'(overflow), 32'(1'b0));
    @(posedge clockPlaca);
    #1 checkOutput("ovf_pulse", 32'(overflow), 32'(1'b1));
    @(posedge clockPlaca);
    #1 checkOutput("ovf_width", 32'(overflow), 32'(1'b0));
    @(negedge clockPlaca);
    clock1s = 1'b0;
    repeat (3) @(posedge clockPlaca);
    checkOutput("ovf_count", 32'(ovf_count), 32'(1));
    set_model(0, 0, 0, 0, 1'b0);
    scan_all("wrap");

    // level held high for 100 cycles counts exactly once
    @(negedge clockPlaca);
    clock1s = 1'b1;
    repeat (100) @(posedge clockPlaca);
    @(negedge clockPlaca);
    clock1s = 1'b0;
    repeat (3) @(posedge clockPlaca);
    set_model(0, 0, 0, 1, 1'b1);
    scan_all("held");

    // reset while the scan sits on digit 2
    for (int k = 0; k < 4 && m_idx != 2; k++) pulse_disp($sformatf("to2_%0d", k));
    checkOutput("idx_at_2", 32'(digito), 32'(4'b1011));
    do_reset("rst_mid");
    pulse_disp("post_rst");

    checkOutput("sb_empty", 32'(sb.size()), 32'(0));
    checkOutput("ovf_total", 32'(ovf_count), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
